// File: rtl/render_pixel.sv
// rtl/render_pixel.sv - final VGA pixel stage: timing delay, grid/cursor overlay, registered RGB out
module render_pixel #(
    parameter int          FETCH_LATENCY = 2,
    parameter int          LOG_CELL_PX   = 2,
    parameter int          BLINK_FRAMES  = 30,
    parameter logic [11:0] ALIVE_COLOR   = 12'hFFF,
    parameter logic [11:0] GRID_COLOR    = 12'h444,
    parameter logic [11:0] CURSOR_COLOR  = 12'hF00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic        is_alive_in,
    input  logic [7:0]  cursor_x_in,
    input  logic [7:0]  cursor_y_in,
    input  logic        show_grid_in,
    input  logic        paused_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic [11:0] rgb_out
);

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    logic [10:0] hc_pipe [FETCH_LATENCY];
    logic [9:0]  vc_pipe [FETCH_LATENCY];
    logic        hs_pipe [FETCH_LATENCY];
    logic        vs_pipe [FETCH_LATENCY];
    logic        bl_pipe [FETCH_LATENCY];

    logic [10:0] hc_d;
    logic [9:0]  vc_d;
    logic        hs_d;
    logic        vs_d;
    logic        bl_d;

    phase_t      phase_q;
    phase_t      phase_n;
    logic [7:0]  blink_cnt_q;
    logic [7:0]  blink_cnt_n;
    logic        vs_prev_q;
    logic        frame_tick;
    logic        blink_phase;

    logic [7:0]             hc_cell;
    logic [7:0]             vc_cell;
    logic [LOG_CELL_PX-1:0] hc_lo;
    logic [LOG_CELL_PX-1:0] vc_lo;
    logic                   grid;
    logic                   in_cursor_cell;
    logic                   cursor_edge;
    logic                   cursor_on;
    logic [11:0]            pixel_color;

    // Shift the VGA timing through FETCH_LATENCY stages so it lines up with is_alive_in
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < FETCH_LATENCY; i++) begin
                hc_pipe[i] <= '0;
                vc_pipe[i] <= '0;
                hs_pipe[i] <= 1'b1;
                vs_pipe[i] <= 1'b1;
                bl_pipe[i] <= 1'b1;
            end
        end else begin
            hc_pipe[0] <= hcount_in;
            vc_pipe[0] <= vcount_in;
            hs_pipe[0] <= hsync_in;
            vs_pipe[0] <= vsync_in;
            bl_pipe[0] <= blank_in;
            for (int i = 1; i < FETCH_LATENCY; i++) begin
                hc_pipe[i] <= hc_pipe[i-1];
                vc_pipe[i] <= vc_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                bl_pipe[i] <= bl_pipe[i-1];
            end
        end
    end

    assign hc_d = hc_pipe[FETCH_LATENCY-1];
    assign vc_d = vc_pipe[FETCH_LATENCY-1];
    assign hs_d = hs_pipe[FETCH_LATENCY-1];
    assign vs_d = vs_pipe[FETCH_LATENCY-1];
    assign bl_d = bl_pipe[FETCH_LATENCY-1];

    // Frame tick is the falling edge of the delayed vsync
    assign frame_tick = vs_prev_q & ~vs_d;

    // Blink state register: phase, frame counter and vsync edge history
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase_q     <= PH_ON;
            blink_cnt_q <= 8'd0;
            vs_prev_q   <= 1'b1;
        end else begin
            phase_q     <= phase_n;
            blink_cnt_q <= blink_cnt_n;
            vs_prev_q   <= vs_d;
        end
    end

    // Blink next state: count frames, toggle phase on the last frame of each half-period
    always_comb begin
        phase_n     = phase_q;
        blink_cnt_n = blink_cnt_q;
        if (frame_tick) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_n = 8'd0;
                phase_n     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt_n = blink_cnt_q + 8'd1;
            end
        end
    end

    // Blink output: cursor visible while in the ON phase
    always_comb begin
        blink_phase = (phase_q == PH_ON);
    end

    // Classify the delayed pixel and pick its colour by priority
    always_comb begin
        hc_cell        = 8'(hc_d >> LOG_CELL_PX);
        vc_cell        = 8'(vc_d >> LOG_CELL_PX);
        hc_lo          = hc_d[LOG_CELL_PX-1:0];
        vc_lo          = vc_d[LOG_CELL_PX-1:0];
        grid           = show_grid_in & ((hc_lo == '0) | (vc_lo == '0));
        in_cursor_cell = (hc_cell == cursor_x_in) & (vc_cell == cursor_y_in);
        cursor_edge    = in_cursor_cell &
                         ((hc_lo == '0) | (&hc_lo) | (vc_lo == '0) | (&vc_lo));
        cursor_on      = cursor_edge & (paused_in | blink_phase);
        pixel_color    = 12'h000;
        if (bl_d) begin
            pixel_color = 12'h000;
        end else if (cursor_on) begin
            pixel_color = CURSOR_COLOR;
        end else if (is_alive_in) begin
            pixel_color = ALIVE_COLOR;
        end else if (grid) begin
            pixel_color = GRID_COLOR;
        end
    end

    // Output register driving the VGA pins
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
            rgb_out   <= 12'h000;
        end else begin
            hsync_out <= hs_d;
            vsync_out <= vs_d;
            blank_out <= bl_d;
            rgb_out   <= pixel_color;
        end
    end

endmodule

// File: doc/render_pixel.md
Name: render_pixel

Overview:
- Final pixel stage of the render path, directly downstream of render_fetch.
- Delays the VGA timing signals so they line up with the is_alive stream from render_fetch.
- Overlays the cell grid lines and a blinking cursor on that stream.
- Drives the registered 12-bit RGB, sync and blank outputs to the VGA pins.

Parameters:
- FETCH_LATENCY, 2: cycles from hcount/vcount presented to render_fetch until the matching is_alive_in is valid; range 1..8.
- LOG_CELL_PX, 2: log2 of the on-screen cell size in pixels (default 4x4 px).
- BLINK_FRAMES, 30: frames per cursor blink half-period; range 1..255.
- ALIVE_COLOR, 12'hFFF: RGB for live cells.
- GRID_COLOR, 12'h444: RGB for grid lines.
- CURSOR_COLOR, 12'hF00: RGB for the cursor border.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous reset, active-high
- hcount_in  input  11  pixel x from the VGA timing generator, same cycle as fed to render_fetch
- vcount_in  input  10  pixel y, same cycle as fed to render_fetch
- hsync_in  input  1  horizontal sync, active-low
- vsync_in  input  1  vertical sync, active-low
- blank_in  input  1  1 = outside the visible area
- is_alive_in  input  1  cell state from render_fetch, FETCH_LATENCY cycles after hcount_in/vcount_in
- cursor_x_in  input  8  cursor column in screen-cell units (hcount >> LOG_CELL_PX)
- cursor_y_in  input  8  cursor row in screen-cell units (vcount >> LOG_CELL_PX)
- show_grid_in  input  1  enable grid lines
- paused_in  input  1  1 = simulation paused; cursor drawn solid
- hsync_out  output  1  delayed hsync
- vsync_out  output  1  delayed vsync
- blank_out  output  1  delayed blank
- rgb_out  output  12  {R[3:0],G[3:0],B[3:0]}

Behaviour:
- Reset (async, rst_in=1):
  - hsync_out=1, vsync_out=1, blank_out=1, rgb_out=0.
  - All delay-line stages cleared to inactive: sync=1, blank=1, counts=0.
  - Blink counter=0, blink phase=1 (cursor visible).
  - Release is synchronous to clk_in.
- Delay line:
  - hcount, vcount, hsync, vsync and blank are shifted through exactly FETCH_LATENCY register stages, producing the hc_d, vc_d, hs_d, vs_d and bl_d values.
  - Those delayed values are aligned with is_alive_in.
- Output stage:
  - One register stage; all outputs are registered.
  - Latency: timing inputs to outputs = FETCH_LATENCY+1 cycles; is_alive_in to rgb_out = 1 cycle.
- Pixel classification, on the delayed values:
  - grid = show_grid_in & (hc_d[LOG_CELL_PX-1:0]==0 | vc_d[LOG_CELL_PX-1:0]==0).
  - in_cursor_cell = (hc_d>>LOG_CELL_PX)[7:0]==cursor_x_in & (vc_d>>LOG_CELL_PX)[7:0]==cursor_y_in.
  - cursor_edge = in_cursor_cell & low LOG_CELL_PX bits of hc_d or vc_d all-0 or all-1.
  - cursor_on = cursor_edge & (paused_in | blink_phase).
- Colour priority (highest first):
  - bl_d=1 -> 0
  - cursor_on -> CURSOR_COLOR
  - is_alive_in -> ALIVE_COLOR
  - grid -> GRID_COLOR
  - otherwise -> 0
- Blink FSM:
  - Frame tick = falling edge of vs_d (previous vs_d=1, current vs_d=0), detected with one extra register.
  - Each tick: if counter==BLINK_FRAMES-1, counter<=0 and blink_phase toggles; else counter increments.
  - Counter is 8 bits and never exceeds BLINK_FRAMES-1.
- Input sampling:
  - paused_in, show_grid_in, cursor_x_in and cursor_y_in are sampled combinationally at the output stage; no internal synchronisation (same clock domain).
  - A change mid-line takes effect on the next output pixel.
  - paused_in rising forces the cursor visible immediately and leaves the counter and phase untouched.
- Boundary conditions:
  - Cursor coordinates beyond the visible cell range never match; no cursor is drawn, no error.
  - hcount beyond 255 cells wraps via the [7:0] truncation; this only occurs during blanking, which overrides it.
  - A vs_d tick and reset in the same cycle: reset wins.
  - Reset mid-frame blanks the outputs until the delay line refills with real timing, FETCH_LATENCY+1 cycles after release.

Test Plan:
- Reset, FETCH_LATENCY=2: assert rst_in during active video -> outputs immediately hsync=1, vsync=1, blank=1, rgb=0. Release, drive hsync_in=0 at cycle N -> hsync_out=0 at cycle N+3.
- Latency: blank_in=0, show_grid_in=0, is_alive_in=1 for exactly one cycle at cycle N (aligned with hcount=37 driven at N-2) -> rgb_out=12'hFFF only at N+1, 0 otherwise.
- Grid: show_grid_in=1, is_alive_in=0, sweep hcount 0..15 with vcount=5 -> rgb=12'h444 exactly for hc_d=0,4,8,12, else 0. Assert blank_in -> rgb=0 regardless.
- Cursor priority: cursor=(3,2), paused_in=1, is_alive_in=1, pixel (12,9) -> 12'hF00. Pixel (13,9) -> 12'hFFF. Pixel (15,10) -> 12'hF00.
- Blink: BLINK_FRAMES=2, paused_in=0, generate 4 vsync falling edges -> phase on for frames 0-1, off for 2-3, on again after the 4th tick. Cursor pixel shows 12'hF00 / (alive or 0) accordingly.
- Mid-operation reset: assert rst_in between vsync ticks with counter=1, phase=0 -> after release counter=0, phase=1, and the cursor is visible on the first frame.
